// File: rtl/inst_fetcher_pkg.sv
// Shared sizes, boolean constants and fetcher state encodings for the fetch stage.
package inst_fetcher_pkg;

    localparam int ADDR_SIZE = 32;
    localparam int INST_SIZE = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        IF_IDLE     = 2'd0,
        IF_WAIT_MEM = 2'd1,
        IF_FILL     = 2'd2
    } if_state_e;

endpackage

// File: rtl/inst_fetcher.sv
// Fetch stage: looks the PC up in the icache each cycle, issues on hit, refills from
// memory on miss, and accepts commit-side redirects in every state.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_SIZE,
    parameter int                INST_W   = INST_SIZE,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_hit,
    input  logic [INST_W-1:0] ic_inst,
    output logic              ic_put,
    output logic [ADDR_W-1:0] ic_put_addr,
    output logic [INST_W-1:0] ic_put_inst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [INST_W-1:0] mem_inst,
    input  logic              iss_full,
    output logic              iss_valid,
    output logic [INST_W-1:0] iss_inst,
    output logic [ADDR_W-1:0] iss_pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_pc
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              ic_put_q, ic_put_d;
    logic [ADDR_W-1:0] ic_put_addr_q, ic_put_addr_d;
    logic [INST_W-1:0] ic_put_inst_q, ic_put_inst_d;
    logic              iss_valid_q, iss_valid_d;
    logic [INST_W-1:0] iss_inst_q, iss_inst_d;
    logic [ADDR_W-1:0] iss_pc_q, iss_pc_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        ic_put_d      = FALSE;
        ic_put_addr_d = ic_put_addr_q;
        ic_put_inst_d = ic_put_inst_q;
        iss_valid_d   = FALSE;
        iss_inst_d    = iss_inst_q;
        iss_pc_d      = iss_pc_q;

        // A redirect always wins over whatever the current state would do with pc.
        if (jump) pc_d = jump_pc;

        case (state_q)
            IF_IDLE: begin
                if (!jump) begin
                    if (ic_hit) begin
                        if (!iss_full) begin
                            iss_valid_d = TRUE;
                            iss_inst_d  = ic_inst;
                            iss_pc_d    = pc_q;
                            pc_d        = pc_q + ADDR_W'(4);
                        end
                    end else begin
                        mem_req_d  = TRUE;
                        mem_addr_d = pc_q;
                        state_d    = IF_WAIT_MEM;
                    end
                end
            end
            IF_WAIT_MEM: begin
                // The in-flight word is written even after a redirect: it is valid for its own address.
                if (mem_done) begin
                    mem_req_d     = FALSE;
                    ic_put_d      = TRUE;
                    ic_put_addr_d = mem_addr_q;
                    ic_put_inst_d = mem_inst;
                    state_d       = IF_FILL;
                end
            end
            IF_FILL: state_d = IF_IDLE;
            default: state_d = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IF_IDLE;
            pc_q          <= RESET_PC;
            mem_req_q     <= FALSE;
            mem_addr_q    <= '0;
            ic_put_q      <= FALSE;
            ic_put_addr_q <= '0;
            ic_put_inst_q <= '0;
            iss_valid_q   <= FALSE;
            iss_inst_q    <= '0;
            iss_pc_q      <= '0;
        end else if (rdy) begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            ic_put_q      <= ic_put_d;
            ic_put_addr_q <= ic_put_addr_d;
            ic_put_inst_q <= ic_put_inst_d;
            iss_valid_q   <= iss_valid_d;
            iss_inst_q    <= iss_inst_d;
            iss_pc_q      <= iss_pc_d;
        end
    end

    assign ic_addr     = pc_q;
    assign ic_put      = ic_put_q;
    assign ic_put_addr = ic_put_addr_q;
    assign ic_put_inst = ic_put_inst_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign iss_valid   = iss_valid_q;
    assign iss_inst    = iss_inst_q;
    assign iss_pc      = iss_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: a per-cycle vector table, directed miss/redirect/reset
// sequences, then random traffic checked against a program-order issue model.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst, rdy, ic_hit, mem_done, iss_full, jump;
    logic [31:0] ic_inst, mem_inst, jump_pc;
    logic [31:0] ic_addr, ic_put_addr, ic_put_inst, mem_addr, iss_inst, iss_pc;
    logic        ic_put, mem_req, iss_valid;

    int errors = 0;
    int checks = 0;

    inst_fetcher #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_inst(ic_inst),
        .ic_put(ic_put), .ic_put_addr(ic_put_addr), .ic_put_inst(ic_put_inst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_inst(mem_inst),
        .iss_full(iss_full), .iss_valid(iss_valid), .iss_inst(iss_inst), .iss_pc(iss_pc),
        .jump(jump), .jump_pc(jump_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, hit, full, jmp, e_valid;
        logic [31:0] inst, jpc, e_pc, e_inst, e_addr;
    } vec_t;

    vec_t tv[11];

    function automatic vec_t mk(logic r, logic h, logic [31:0] i, logic f, logic j, logic [31:0] jp,
                                logic ev, logic [31:0] ep, logic [31:0] ei, logic [31:0] ea);
        vec_t v;
        v.rdy = r; v.hit = h; v.inst = i; v.full = f; v.jmp = j; v.jpc = jp;
        v.e_valid = ev; v.e_pc = ep; v.e_inst = ei; v.e_addr = ea;
        return v;
    endfunction

    // Reference program image: the word any address holds in memory.
    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    localparam logic [31:0] A0 = 32'h1000_0013, A4 = 32'h1040_0013, A8 = 32'h1080_0013;
    localparam logic [31:0] AC = 32'h10C0_0013, B0 = 32'h2000_0093, B4 = 32'h2040_0093;

    bit cached [logic [31:0]];

    initial begin
        logic [31:0] exp_pc, b_addr, b_pc, b_inst, r_jpc;
        logic        b_req, b_put, b_valid, r_rdy, r_jump, r_done;
        int          delay, issues;

        rst = 1'b1; rdy = 1'b1; ic_hit = 1'b0; ic_inst = '0; mem_done = 1'b0; mem_inst = '0;
        iss_full = 1'b0; jump = 1'b0; jump_pc = '0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ic_put", 32'(ic_put), 32'd0);
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_put_addr", ic_put_addr, 32'd0);
        chk("rst_put_inst", ic_put_inst, 32'd0);
        chk("rst_iss_inst", iss_inst, 32'd0);
        chk("rst_iss_pc", iss_pc, 32'd0);
        chk("rst_ic_addr", ic_addr, 32'd0);

        // Hits, freeze, backpressure, redirect-over-hit, all from pc=0.
        tv[0]  = mk(1, 1, A0, 0, 0, 0,      1, 32'h0,   A0, 32'h4);
        tv[1]  = mk(1, 1, A4, 0, 0, 0,      1, 32'h4,   A4, 32'h8);
        tv[2]  = mk(0, 1, A8, 0, 0, 0,      1, 32'h4,   A4, 32'h8);
        tv[3]  = mk(1, 1, A8, 1, 0, 0,      0, 32'h4,   A4, 32'h8);
        tv[4]  = mk(1, 1, A8, 1, 0, 0,      0, 32'h4,   A4, 32'h8);
        tv[5]  = mk(1, 1, A8, 1, 0, 0,      0, 32'h4,   A4, 32'h8);
        tv[6]  = mk(1, 1, A8, 0, 0, 0,      1, 32'h8,   A8, 32'hC);
        tv[7]  = mk(1, 1, AC, 0, 1, 32'h8,  0, 32'h8,   A8, 32'h8);
        tv[8]  = mk(1, 1, A8, 0, 1, 32'h100,0, 32'h8,   A8, 32'h100);
        tv[9]  = mk(1, 1, B0, 0, 0, 0,      1, 32'h100, B0, 32'h104);
        tv[10] = mk(1, 1, B4, 1, 0, 0,      0, 32'h100, B0, 32'h104);
        for (int i = 0; i < 11; i++) begin
            rdy = tv[i].rdy; ic_hit = tv[i].hit; ic_inst = tv[i].inst; iss_full = tv[i].full;
            jump = tv[i].jmp; jump_pc = tv[i].jpc;
            tick();
            chk($sformatf("tv%0d_valid", i), 32'(iss_valid), 32'(tv[i].e_valid));
            chk($sformatf("tv%0d_pc", i), iss_pc, tv[i].e_pc);
            chk($sformatf("tv%0d_inst", i), iss_inst, tv[i].e_inst);
            chk($sformatf("tv%0d_addr", i), ic_addr, tv[i].e_addr);
        end
        rdy = 1'b1; jump = 1'b0; iss_full = 1'b0;

        // Cold miss at 0x0 with a 5-cycle memory response.
        do_reset();
        ic_hit = 1'b0;
        tick();
        chk("miss_req", 32'(mem_req), 32'd1);
        chk("miss_addr", mem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wait_req", 32'(mem_req), 32'd1);
            chk("wait_addr", mem_addr, 32'h0);
            chk("wait_noput", 32'(ic_put), 32'd0);
        end
        mem_done = 1'b1; mem_inst = 32'h0050_0093;
        tick();
        mem_done = 1'b0; mem_inst = '0;
        chk("done_req", 32'(mem_req), 32'd0);
        chk("done_put", 32'(ic_put), 32'd1);
        chk("done_put_addr", ic_put_addr, 32'h0);
        chk("done_put_inst", ic_put_inst, 32'h0050_0093);
        tick();
        chk("fill_put_off", 32'(ic_put), 32'd0);
        chk("fill_noissue", 32'(iss_valid), 32'd0);
        ic_hit = 1'b1; ic_inst = 32'h0050_0093;
        tick();
        chk("refill_issue", 32'(iss_valid), 32'd1);
        chk("refill_pc", iss_pc, 32'h0);
        chk("refill_inst", iss_inst, 32'h0050_0093);

        // Redirect while waiting on the miss for 0x40.
        ic_hit = 1'b0; jump = 1'b1; jump_pc = 32'h40;
        tick();
        chk("jmp40_addr", ic_addr, 32'h40);
        chk("jmp40_noreq", 32'(mem_req), 32'd0);
        jump = 1'b0;
        tick();
        chk("m40_req", 32'(mem_req), 32'd1);
        chk("m40_addr", mem_addr, 32'h40);
        jump = 1'b1; jump_pc = 32'h200;
        tick();
        jump = 1'b0;
        chk("m40_req_held", 32'(mem_req), 32'd1);
        chk("m40_addr_held", mem_addr, 32'h40);
        chk("m40_lookup", ic_addr, 32'h200);
        mem_done = 1'b1; mem_inst = 32'hCAFE_0040; ic_hit = 1'b1; ic_inst = 32'hBAD0_0000;
        tick();
        mem_done = 1'b0;
        chk("m40_put", 32'(ic_put), 32'd1);
        chk("m40_put_addr", ic_put_addr, 32'h40);
        chk("m40_noissue", 32'(iss_valid), 32'd0);
        tick();
        chk("m40_fill_noissue", 32'(iss_valid), 32'd0);
        chk("m40_next_lookup", ic_addr, 32'h200);
        ic_inst = 32'h0000_0200;
        tick();
        chk("j200_issue", 32'(iss_valid), 32'd1);
        chk("j200_pc", iss_pc, 32'h200);

        // Reset while waiting, then a stray completion.
        ic_hit = 1'b0;
        tick();
        chk("m204_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_req", 32'(mem_req), 32'd0);
        chk("rstw_put", 32'(ic_put), 32'd0);
        chk("rstw_pc", ic_addr, 32'h0);
        mem_done = 1'b1; mem_inst = 32'hDEAD_BEEF; ic_hit = 1'b1; ic_inst = A0;
        tick();
        mem_done = 1'b0;
        chk("stray_noput", 32'(ic_put), 32'd0);
        chk("restart_issue", 32'(iss_valid), 32'd1);
        chk("restart_pc", iss_pc, 32'h0);

        // pc wraps past the top of the address space.
        ic_hit = 1'b0; jump = 1'b1; jump_pc = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0; ic_hit = 1'b1; ic_inst = A8;
        tick();
        chk("wrap_pc", iss_pc, 32'hFFFF_FFFC);
        chk("wrap_next", ic_addr, 32'h0);

        // Random traffic: cache and memory models plus an expected-next-issue-PC tracker.
        do_reset();
        cached.delete();
        exp_pc = 32'h0; delay = 0; issues = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rdy      = ($urandom % 8) != 0;
            jump     = ($urandom % 12) == 0;
            jump_pc  = 32'($urandom_range(0, 255)) << 2;
            iss_full = ($urandom % 4) == 0;
            ic_hit   = cached.exists(ic_addr);
            ic_inst  = ic_hit ? img(ic_addr) : $urandom;
            if (mem_req) begin
                mem_done = (delay == 0);
                mem_inst = img(mem_addr);
            end else begin
                mem_done = ($urandom % 20) == 0;
                mem_inst = $urandom;
            end
            r_rdy = rdy; r_jump = jump; r_jpc = jump_pc; r_done = mem_done;
            b_req = mem_req; b_addr = mem_addr; b_put = ic_put;
            b_valid = iss_valid; b_pc = iss_pc; b_inst = iss_inst;
            tick();
            if (r_rdy) begin
                chk("r_put", 32'(ic_put), 32'(r_done && b_req));
                if (ic_put) begin
                    chk("r_put_addr", ic_put_addr, b_addr);
                    chk("r_put_inst", ic_put_inst, img(b_addr));
                    cached[ic_put_addr] = 1'b1;
                end
                if (r_jump) begin
                    chk("r_jump_noissue", 32'(iss_valid), 32'd0);
                    exp_pc = r_jpc;
                end else if (iss_valid) begin
                    chk("r_iss_pc", iss_pc, exp_pc);
                    chk("r_iss_inst", iss_inst, img(iss_pc));
                    exp_pc = iss_pc + 32'd4;
                    issues++;
                end
                if (b_req && mem_req) chk("r_addr_stable", mem_addr, b_addr);
                if (mem_req && !b_req) delay = $urandom_range(0, 4);
                else if (mem_req && delay > 0) delay--;
            end else begin
                chk("r_freeze_valid", 32'(iss_valid), 32'(b_valid));
                chk("r_freeze_pc", iss_pc, b_pc);
                chk("r_freeze_inst", iss_inst, b_inst);
                chk("r_freeze_put", 32'(ic_put), 32'(b_put));
                chk("r_freeze_req", 32'(mem_req), 32'(b_req));
            end
        end
        chk("r_liveness", 32'(issues > 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Fetch stage directly upstream of the instruction cache.
- Owns the PC and looks it up in the cache every cycle. On a hit it issues the instruction to decode/issue.
- On a miss it fetches the word from the memory controller, writes it into the cache, then retries the lookup.
- Takes PC redirects from commit on mispredict or jump.

Parameters:
- ADDR_W, 32, address width (matches `Addr_SIZE`).
- INST_W, 32, instruction width (matches `Inst_SIZE`).
- RESET_PC, 32'h0, PC after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; low = freeze all state
- ic_addr  out  ADDR_W  lookup address to cache; combinational copy of pc
- ic_hit  in  1  cache hit for ic_addr
- ic_inst  in  INST_W  cached instruction
- ic_put  out  1  one-cycle cache write strobe
- ic_put_addr  out  ADDR_W  write address
- ic_put_inst  out  INST_W  write data
- mem_req  out  1  fetch request to memory controller, level-held
- mem_addr  out  ADDR_W  fetch address
- mem_done  in  1  one-cycle completion pulse
- mem_inst  in  INST_W  fetched word, valid with mem_done
- iss_full  in  1  downstream cannot accept this cycle
- iss_valid  out  1  one-cycle issue pulse
- iss_inst  out  INST_W  issued instruction
- iss_pc  out  ADDR_W  PC of issued instruction
- jump  in  1  redirect request
- jump_pc  in  ADDR_W  redirect target

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=IDLE.
  - mem_req=0, ic_put=0, iss_valid=0.
  - mem_addr, ic_put_addr, ic_put_inst, iss_inst, iss_pc = 0.
  - Reset mid-WAIT_MEM abandons the request. A later stray mem_done is ignored because state is IDLE.
- rdy=0: no register changes; outputs hold.
- All outputs except ic_addr are registered. ic_addr = pc.
- States: IDLE, WAIT_MEM, FILL.
- Default each cycle: iss_valid<=0, ic_put<=0.
- IDLE:
  - jump=1: pc<=jump_pc; no issue.
  - else if ic_hit and !iss_full: iss_valid<=1, iss_inst<=ic_inst, iss_pc<=pc, pc<=pc+4. Throughput is 1 instruction per cycle on consecutive hits.
  - else if ic_hit and iss_full: hold pc, no issue.
  - else (miss): mem_req<=1, mem_addr<=pc, go to WAIT_MEM. A miss is taken regardless of iss_full.
- WAIT_MEM:
  - mem_req stays 1 and mem_addr stays stable until mem_done.
  - On mem_done: mem_req<=0; ic_put<=1, ic_put_addr<=mem_addr, ic_put_inst<=mem_inst; go to FILL.
  - jump here: pc<=jump_pc. The in-flight request completes normally and its word is still written to the cache (it is tag-correct for its own address).
  - jump coincident with mem_done: both take effect.
- FILL:
  - ic_put is high this cycle; cache lookup results are not used.
  - jump: pc<=jump_pc. Always go to IDLE next.
- Miss penalty: request at cycle t+1 after the IDLE miss. The hit is re-evaluated 2 cycles after mem_done.
- pc+4 wraps modulo 2^ADDR_W.
- mem_done outside WAIT_MEM is ignored.
- jump has priority over issue in the same cycle. No instruction from the old path is issued after the cycle jump is sampled.

Decomposition:
- Shared defines header carries: `Addr_SIZE`, `Inst_SIZE`, `True`/`False`, and fetcher state encodings (IF_IDLE, IF_WAIT_MEM, IF_FILL, 2 bits).
- Single flat module; no sub-module needed.

Test Plan:
1. Reset, cache pre-filled at 0x0, 0x4, 0x8, iss_full=0:
   - iss_valid pulses on 3 consecutive cycles with iss_pc=0x0, 0x4, 0x8 and matching iss_inst.
2. Cold miss at 0x0, mem_done 5 cycles after mem_req with mem_inst=0x00500093:
   - mem_addr=0x0 held while mem_req is high.
   - ic_put=1 with addr 0x0 for exactly 1 cycle.
   - iss_valid with iss_inst=0x00500093, iss_pc=0x0 two cycles after mem_done.
3. Hit with iss_full=1 for 3 cycles:
   - No iss_valid; pc holds.
   - On release, a single issue of the held PC.
4. jump=1, jump_pc=0x100 in the same cycle as a hit at 0x8:
   - 0x8 not issued.
   - Next issue has iss_pc=0x100.
5. jump to 0x200 during WAIT_MEM for 0x40:
   - Fill still writes 0x40.
   - No issue of 0x40.
   - Next lookup is 0x200.
6. rst asserted during WAIT_MEM, then a stray mem_done:
   - mem_req=0 and no ic_put.
   - Fetch restarts at RESET_PC.
